rr_arbiter16: RTL and testbench
===============================

// Module: rr_arbiter16
// PURPOSE
//  16-requester round-robin arbiter that shares one resource between 16 clients.
//  The winner index is registered as a 4-bit code. A one-hot grant vector is
//  produced by a 4-to-16 decoder sub-block, with the same bit ordering as the
//  decoder outputs (bit k <-> code k).
//  Holds each grant until the requester releases it or a hold timeout preempts it.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles per winner; 0 = no timeout (8-bit counter)
//  PTR_INIT  0  priority pointer value after reset (0..15)
// PORTS
//  clk        in   1        system clock, all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  en         in   1        1 = new grants allowed; 0 = no new grants (current one continues)
//  req        in   [0:15]   request vector; req[k] high = client k wants resource
//  gnt        out  [0:15]   one-hot grant; gnt[k]=1 iff gnt_valid && gnt_id==k
//  gnt_id     out  4        registered index of current winner
//  gnt_valid  out  1        a grant is active
//  preempt    out  1        1-cycle pulse: current grant ended by timeout, not by release
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0,
//   hold_cnt=0, ptr=PTR_INIT. Reset dominates all inputs, incl. mid-grant.
//  States: IDLE (no grant), GRANT (gnt_valid=1).
//  Search: cyclic scan of req from ptr upward, 15 wraps to 0; first set bit wins.
//  IDLE: if en && |req -> GRANT, gnt_id=winner, hold_cnt=0. Latency: req seen at edge t,
//   gnt valid after edge t+1 (1 cycle). Else stay IDLE.
//  GRANT: release when req[gnt_id]==0; timeout when MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1
//   && req[gnt_id]==1. Otherwise hold_cnt++ and the grant is held.
//  On release or timeout (same edge):
//   - ptr <= gnt_id+1 (mod 16).
//   - preempt <= 1 only on timeout.
//   - Zero-bubble handover: the search restarts at gnt_id+1. If en && a winner exists,
//     stay in GRANT with the new gnt_id and hold_cnt=0. Otherwise go to IDLE.
//   - A preempted client still requesting is scanned last, so it re-wins only if it is alone.
//  en=0 in GRANT: current grant continues, and its timeout still applies. At release,
//   go to IDLE, no handover.
//  Simultaneous events:
//   - Requests that rise during GRANT wait for the next arbitration.
//   - Release and timeout in the same cycle count as a release (preempt=0).
//  gnt is the decoder output driven by registered gnt_id/gnt_valid, so it changes only
//   after clk edges.
//  gnt is glitch-free relative to registered inputs and never has >1 bit set.
// STRUCTURE
//  Shared include arb_defs.vh: state encodings ST_IDLE=1'b0, ST_GRANT=1'b1, NREQ=16, IDW=4.
//  Sub-module grant_dec4to16 (w[3:0], en -> y[0:15]): w=gnt_id, en=gnt_valid.
//  Top level: FSM, pointer, hold counter, cyclic priority search (loop over offset 0..15).
// TESTING
//  1 Reset: rst=1 for 2 cycles with req=all ones -> gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
//  2 Single client: req[5]=1 at edge t -> gnt_id=5, gnt only bit5 after t+1.
//    Drop req[5] before edge t+4 -> gnt=0 after edge t+4, ptr=6.
//  3 Round robin, MAX_HOLD=4: req bits 1,4,6 held high -> grants 1,4,6,1,
//    4 cycles each, no idle gap, preempt pulses each handover.
//  4 Wrap: winner 15 releases while req{0,15} high -> next gnt_id=0; then 15 after 0 releases.
//  5 Enable gate: en=0, req[3]=1 for 5 cycles -> no grant; en=1 -> gnt_id=3 one cycle later.
//  6 Reset mid-grant: gnt_id=9 active, rst=1 one cycle -> gnt=0 next edge, ptr=PTR_INIT;
//    after rst drops with req[9], req[2] high -> winner 2.

Source files
------------

// File: rtl/rr_arbiter16_pkg.sv
// Shared types and the cyclic priority search for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;

    localparam int unsigned NREQ = 16;
    localparam int unsigned IDW  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic           found;
        logic [IDW-1:0] id;
    } win_t;

    // First set request scanning upward from base, wrapping 15 -> 0.
    function automatic win_t rr_search(input logic [0:NREQ-1] r, input logic [IDW-1:0] base);
        win_t           res;
        logic [IDW-1:0] idx;
        res = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = base + IDW'(off);
            if (!res.found && r[idx]) begin
                res.found = 1'b1;
                res.id    = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter16_dec.sv
// 4-to-16 one-hot decoder; output bit k is set for code k while enabled.
module grant_dec4to16 (
    input  logic [3:0]  w,
    input  logic        en,
    output logic [0:15] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with hold timeout and zero-bubble handover.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned PTR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [0:15] req,
    output logic [0:15] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_valid,
    output logic        preempt
);

    localparam logic [IDW-1:0] PTR_RST   = IDW'(PTR_INIT);
    localparam logic [7:0]     HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t         state_q;
    logic [IDW-1:0] gnt_id_q;
    logic [IDW-1:0] ptr_q;
    logic [7:0]     hold_cnt_q;
    logic           preempt_q;

    logic           cur_req;
    logic           release_w;
    logic           timeout_w;
    logic [IDW-1:0] search_base;
    win_t           win;

    // While granting, the search starts just past the holder so it is scanned last.
    always_comb begin
        cur_req     = req[gnt_id_q];
        release_w   = (state_q == ST_GRANT) && !cur_req;
        timeout_w   = (state_q == ST_GRANT) && (MAX_HOLD != 0) &&
                      (hold_cnt_q == HOLD_LAST) && cur_req;
        search_base = (state_q == ST_GRANT) ? gnt_id_q + 4'd1 : ptr_q;
        win         = rr_search(req, search_base);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_id_q   <= '0;
            ptr_q      <= PTR_RST;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hold_cnt_q <= '0;
                    if (en && win.found) begin
                        state_q  <= ST_GRANT;
                        gnt_id_q <= win.id;
                    end
                end
                ST_GRANT: begin
                    if (release_w || timeout_w) begin
                        ptr_q      <= gnt_id_q + 4'd1;
                        preempt_q  <= timeout_w;
                        hold_cnt_q <= '0;
                        if (en && win.found) begin
                            gnt_id_q <= win.id;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_id    = gnt_id_q;
    assign gnt_valid = (state_q == ST_GRANT);
    assign preempt   = preempt_q;

    grant_dec4to16 u_dec (
        .w  (gnt_id_q),
        .en (gnt_valid),
        .y  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed scoreboard bench for rr_arbiter16 configured with MAX_HOLD=4, PTR_INIT=0.
module tb_rr_arbiter16;

    logic        clk;
    logic        rst;
    logic        en;
    logic [0:15] req;
    logic [0:15] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        preempt;

    int checks = 0;
    int errors = 0;

    string tag_q[$];
    int    expv_q[$];
    int    expid_q[$];
    int    expp_q[$];

    rr_arbiter16 #(
        .MAX_HOLD (4),
        .PTR_INIT (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:15] bits(input int a, input int b = -1, input int c = -1);
        logic [0:15] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    // id < 0 means gnt_id is not checked for this step
    task automatic expect_next(input string tag, input int v, input int id, input int p);
        tag_q.push_back(tag);
        expv_q.push_back(v);
        expid_q.push_back(id);
        expp_q.push_back(p);
    endtask

    task automatic cyc();
        string       t;
        int          v, id, p;
        logic [0:15] eg;
        @(posedge clk);
        #1;
        while (tag_q.size() > 0) begin
            t  = tag_q.pop_front();
            v  = expv_q.pop_front();
            id = expid_q.pop_front();
            p  = expp_q.pop_front();
            eg = '0;
            if (v != 0) eg[id] = 1'b1;
            checks++;
            assert (gnt === eg) else begin
                errors++;
                $error("FAIL %s gnt observed=%b expected=%b", t, gnt, eg);
            end
            checks++;
            assert (gnt_valid === (v != 0)) else begin
                errors++;
                $error("FAIL %s gnt_valid observed=%b expected=%0d", t, gnt_valid, v);
            end
            checks++;
            assert (preempt === (p != 0)) else begin
                errors++;
                $error("FAIL %s preempt observed=%b expected=%0d", t, preempt, p);
            end
            if (id >= 0) begin
                checks++;
                assert (gnt_id === 4'(id)) else begin
                    errors++;
                    $error("FAIL %s gnt_id observed=%0d expected=%0d", t, gnt_id, id);
                end
            end
        end
    endtask

    initial begin
        int seq[4];
        seq = '{1, 4, 6, 1};

        // Reset with all requests asserted
        rst = 1'b1; en = 1'b1; req = '1;
        expect_next("reset0", 0, 0, 0); cyc();
        expect_next("reset1", 0, 0, 0); cyc();

        // Single client 5, released before its timeout
        rst = 1'b0; req = bits(5);
        expect_next("single_grant", 1, 5, 0); cyc();
        expect_next("single_hold1", 1, 5, 0); cyc();
        expect_next("single_hold2", 1, 5, 0); cyc();
        req = '0;
        expect_next("single_release", 0, -1, 0); cyc();
        // ptr now 6: 7 must beat 2
        req = bits(2, 7);
        expect_next("ptr_after_5", 1, 7, 0); cyc();
        req = '0;
        expect_next("release_7", 0, -1, 0); cyc();

        // Round robin over 1,4,6 with 4-cycle timeouts (ptr starts at 8)
        req = bits(1, 4, 6);
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++) begin
                expect_next($sformatf("rr_g%0d_c%0d", g, c), 1, seq[g], (c == 0 && g > 0) ? 1 : 0);
                cyc();
            end
        end
        req = '0;
        expect_next("rr_release", 0, -1, 0); cyc();

        // Wrap, plus lone client re-winning after its own timeout (ptr = 2)
        req = bits(0, 15);
        expect_next("wrap_15", 1, 15, 0); cyc();
        req = bits(0);
        expect_next("wrap_to_0", 1, 0, 0); cyc();
        req = bits(15);
        expect_next("wrap_0_to_15", 1, 15, 0); cyc();
        expect_next("lone_h1", 1, 15, 0); cyc();
        expect_next("lone_h2", 1, 15, 0); cyc();
        expect_next("lone_h3", 1, 15, 0); cyc();
        expect_next("lone_rewin", 1, 15, 1); cyc();
        req = '0;
        expect_next("lone_release", 0, -1, 0); cyc();

        // Enable gate, then timeout with en=0 drops to idle
        en = 1'b0; req = bits(3);
        for (int i = 0; i < 5; i++) begin
            expect_next($sformatf("en_gate_%0d", i), 0, -1, 0); cyc();
        end
        en = 1'b1;
        expect_next("en_grant_3", 1, 3, 0); cyc();
        en = 1'b0;
        expect_next("en0_hold1", 1, 3, 0); cyc();
        expect_next("en0_hold2", 1, 3, 0); cyc();
        expect_next("en0_hold3", 1, 3, 0); cyc();
        expect_next("en0_timeout", 0, -1, 1); cyc();
        expect_next("en0_idle", 0, -1, 0); cyc();

        // Reset mid-grant restores ptr to 0 (ptr = 4 before this)
        en = 1'b1; req = bits(9);
        expect_next("pre_rst_9", 1, 9, 0); cyc();
        rst = 1'b1; req = bits(2, 9, 12);
        expect_next("mid_reset", 0, 0, 0); cyc();
        rst = 1'b0;
        expect_next("post_rst_2", 1, 2, 0); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
